// File: rtl/axis_1553_pkg.sv
// Shared types and widths for the 1553 string arbiter and its ID FIFO.
package axis_1553_pkg;

  localparam int DEC_DATA_W = 16;
  localparam int DEC_USER_W = 8;

  typedef logic [0:0] port_id_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_1553_id_fifo.sv
// In-flight requester ID FIFO; DEPTH must be a power of two so pointers wrap for free.
module axis_1553_id_fifo
  import axis_1553_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     aclk,
  input  logic     arst,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  port_id_t         mem_q [DEPTH];
  port_id_t         mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axis_1553_string_arbiter.sv
// Two-requester arbiter in front of one shared 1553 string decoder, routing results back by ID.
// Define AXIS_1553_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins) instead of round-robin.
module axis_1553_string_arbiter
  import axis_1553_pkg::*;
#(
  parameter int STR_WIDTH = 176,
  parameter int ID_DEPTH  = 4
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [STR_WIDTH-1:0]  s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [STR_WIDTH-1:0]  s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [STR_WIDTH-1:0]  m_dec_axis_tdata,
  output logic                  m_dec_axis_tvalid,
  input  logic                  m_dec_axis_tready,
  input  logic [DEC_DATA_W-1:0] s_dec_axis_tdata,
  input  logic [DEC_USER_W-1:0] s_dec_axis_tuser,
  input  logic                  s_dec_axis_tvalid,
  output logic                  s_dec_axis_tready,
  output logic [DEC_DATA_W-1:0] m0_axis_tdata,
  output logic [DEC_USER_W-1:0] m0_axis_tuser,
  output logic                  m0_axis_tvalid,
  input  logic                  m0_axis_tready,
  output logic [DEC_DATA_W-1:0] m1_axis_tdata,
  output logic [DEC_USER_W-1:0] m1_axis_tuser,
  output logic                  m1_axis_tvalid,
  input  logic                  m1_axis_tready,
  output logic                  orphan_err
);

  arb_state_e           state_q, state_d;
  logic [STR_WIDTH-1:0] str_q, str_d;
  port_id_t             held_id_q, held_id_d;
`ifndef AXIS_1553_ARB_FIXED_PRIO_EN
  port_id_t             rr_last_q, rr_last_d;
`endif

  port_id_t grant_id;
  logic     can_grant;
  logic     dec_hs;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  port_id_t fifo_head;

  always_comb begin
`ifdef AXIS_1553_ARB_FIXED_PRIO_EN
    grant_id = s0_axis_tvalid ? port_id_t'(0) : port_id_t'(1);
`else
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      grant_id = ~rr_last_q;
    end else begin
      grant_id = s0_axis_tvalid ? port_id_t'(0) : port_id_t'(1);
    end
`endif
    can_grant = !arst && (state_q == ST_IDLE) && !fifo_full &&
                (s0_axis_tvalid || s1_axis_tvalid);
  end

  assign s0_axis_tready    = can_grant && (grant_id == port_id_t'(0));
  assign s1_axis_tready    = can_grant && (grant_id == port_id_t'(1));
  assign m_dec_axis_tvalid = !arst && (state_q == ST_HOLD);
  assign m_dec_axis_tdata  = str_q;
  assign dec_hs            = m_dec_axis_tvalid && m_dec_axis_tready;
  assign fifo_push         = dec_hs;

  // The captured string and ID stay frozen until the decoder accepts them.
  always_comb begin
    state_d   = state_q;
    str_d     = str_q;
    held_id_d = held_id_q;
`ifndef AXIS_1553_ARB_FIXED_PRIO_EN
    rr_last_d = rr_last_q;
`endif
    if (can_grant) begin
      state_d   = ST_HOLD;
      str_d     = (grant_id == port_id_t'(1)) ? s1_axis_tdata : s0_axis_tdata;
      held_id_d = grant_id;
`ifndef AXIS_1553_ARB_FIXED_PRIO_EN
      rr_last_d = grant_id;
`endif
    end else if (dec_hs) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      str_q     <= '0;
      held_id_q <= port_id_t'(0);
`ifndef AXIS_1553_ARB_FIXED_PRIO_EN
      rr_last_q <= port_id_t'(1);
`endif
    end else begin
      state_q   <= state_d;
      str_q     <= str_d;
      held_id_q <= held_id_d;
`ifndef AXIS_1553_ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // Results follow the head ID; with nothing outstanding the word is swallowed and flagged.
  always_comb begin
    m0_axis_tvalid = !arst && s_dec_axis_tvalid && !fifo_empty &&
                     (fifo_head == port_id_t'(0));
    m1_axis_tvalid = !arst && s_dec_axis_tvalid && !fifo_empty &&
                     (fifo_head == port_id_t'(1));
    if (arst) begin
      s_dec_axis_tready = 1'b0;
    end else if (fifo_empty) begin
      s_dec_axis_tready = 1'b1;
    end else begin
      s_dec_axis_tready = (fifo_head == port_id_t'(1)) ? m1_axis_tready : m0_axis_tready;
    end
    fifo_pop   = s_dec_axis_tvalid && s_dec_axis_tready && !fifo_empty;
    orphan_err = !arst && s_dec_axis_tvalid && fifo_empty;
  end

  assign m0_axis_tdata = s_dec_axis_tdata;
  assign m0_axis_tuser = s_dec_axis_tuser;
  assign m1_axis_tdata = s_dec_axis_tdata;
  assign m1_axis_tuser = s_dec_axis_tuser;

  axis_1553_id_fifo #(
    .DEPTH(ID_DEPTH)
  ) u_id_fifo (
    .aclk   (aclk),
    .arst   (arst),
    .push   (fifo_push),
    .push_id(held_id_q),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_axis_1553_string_arbiter.sv
// Bench for axis_1553_string_arbiter: queue-based model checked every cycle plus directed literal checks.
// Honours AXIS_1553_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_axis_1553_string_arbiter;

  localparam int STR_WIDTH = 176;
  localparam int ID_DEPTH  = 4;

  logic                 aclk = 1'b0;
  logic                 arst;
  logic [STR_WIDTH-1:0] s0_axis_tdata, s1_axis_tdata, m_dec_axis_tdata;
  logic                 s0_axis_tvalid, s0_axis_tready;
  logic                 s1_axis_tvalid, s1_axis_tready;
  logic                 m_dec_axis_tvalid, m_dec_axis_tready;
  logic [15:0]          s_dec_axis_tdata, m0_axis_tdata, m1_axis_tdata;
  logic [7:0]           s_dec_axis_tuser, m0_axis_tuser, m1_axis_tuser;
  logic                 s_dec_axis_tvalid, s_dec_axis_tready;
  logic                 m0_axis_tvalid, m0_axis_tready;
  logic                 m1_axis_tvalid, m1_axis_tready;
  logic                 orphan_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int                   id_q[$];
  int                   grant_log[$];
  int                   route_log[$];
  bit                   holding = 1'b0;
  int                   held_id = 0;
  int                   last_id = 1;
  logic [STR_WIDTH-1:0] held_str = '0;

  always #5 aclk = ~aclk;

  axis_1553_string_arbiter #(
    .STR_WIDTH(STR_WIDTH),
    .ID_DEPTH (ID_DEPTH)
  ) dut (
    .aclk             (aclk),
    .arst             (arst),
    .s0_axis_tdata    (s0_axis_tdata),
    .s0_axis_tvalid   (s0_axis_tvalid),
    .s0_axis_tready   (s0_axis_tready),
    .s1_axis_tdata    (s1_axis_tdata),
    .s1_axis_tvalid   (s1_axis_tvalid),
    .s1_axis_tready   (s1_axis_tready),
    .m_dec_axis_tdata (m_dec_axis_tdata),
    .m_dec_axis_tvalid(m_dec_axis_tvalid),
    .m_dec_axis_tready(m_dec_axis_tready),
    .s_dec_axis_tdata (s_dec_axis_tdata),
    .s_dec_axis_tuser (s_dec_axis_tuser),
    .s_dec_axis_tvalid(s_dec_axis_tvalid),
    .s_dec_axis_tready(s_dec_axis_tready),
    .m0_axis_tdata    (m0_axis_tdata),
    .m0_axis_tuser    (m0_axis_tuser),
    .m0_axis_tvalid   (m0_axis_tvalid),
    .m0_axis_tready   (m0_axis_tready),
    .m1_axis_tdata    (m1_axis_tdata),
    .m1_axis_tuser    (m1_axis_tuser),
    .m1_axis_tvalid   (m1_axis_tvalid),
    .m1_axis_tready   (m1_axis_tready),
    .orphan_err       (orphan_err)
  );

  task automatic check_output(input string name, input logic [STR_WIDTH-1:0] act,
                              input logic [STR_WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; requester strings change every cycle so a held string must not follow them.
  task automatic apply_stimulus();
    @(posedge aclk);
    #1;
    s0_axis_tdata = STR_WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    s1_axis_tdata = STR_WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  // Model: outstanding IDs as a queue, one held request, last grant for round-robin.
  always @(negedge aclk) begin : compare
    int  g;
    int  head;
    bit  do_grant;
    bit  exp_ready;
    bit  pop;
    if (arst) begin
      check_output("rst_s0_tready", s0_axis_tready, 0);
      check_output("rst_s1_tready", s1_axis_tready, 0);
      check_output("rst_m_dec_tvalid", m_dec_axis_tvalid, 0);
      check_output("rst_s_dec_tready", s_dec_axis_tready, 0);
      check_output("rst_m0_tvalid", m0_axis_tvalid, 0);
      check_output("rst_m1_tvalid", m1_axis_tvalid, 0);
      check_output("rst_orphan", orphan_err, 0);
      id_q.delete();
      holding = 1'b0;
      last_id = 1;
    end else begin
      do_grant = !holding && (id_q.size() < ID_DEPTH) && (s0_axis_tvalid || s1_axis_tvalid);
`ifdef AXIS_1553_ARB_FIXED_PRIO_EN
      g = s0_axis_tvalid ? 0 : 1;
`else
      g = (s0_axis_tvalid && s1_axis_tvalid) ? 1 - last_id : (s0_axis_tvalid ? 0 : 1);
`endif
      check_output("s0_tready", s0_axis_tready, (do_grant && g == 0) ? 1 : 0);
      check_output("s1_tready", s1_axis_tready, (do_grant && g == 1) ? 1 : 0);
      check_output("m_dec_tvalid", m_dec_axis_tvalid, holding ? 1 : 0);
      if (holding) check_output("m_dec_tdata", m_dec_axis_tdata, held_str);
      pop = 1'b0;
      if (id_q.size() == 0) begin
        exp_ready = 1'b1;
        check_output("orphan", orphan_err, s_dec_axis_tvalid ? 1 : 0);
        check_output("m0_tvalid", m0_axis_tvalid, 0);
        check_output("m1_tvalid", m1_axis_tvalid, 0);
      end else begin
        head      = id_q[0];
        exp_ready = (head == 1) ? m1_axis_tready : m0_axis_tready;
        check_output("orphan", orphan_err, 0);
        check_output("m0_tvalid", m0_axis_tvalid, (s_dec_axis_tvalid && head == 0) ? 1 : 0);
        check_output("m1_tvalid", m1_axis_tvalid, (s_dec_axis_tvalid && head == 1) ? 1 : 0);
        if (s_dec_axis_tvalid && head == 0) begin
          check_output("m0_tdata", m0_axis_tdata, s_dec_axis_tdata);
          check_output("m0_tuser", m0_axis_tuser, s_dec_axis_tuser);
        end
        if (s_dec_axis_tvalid && head == 1) begin
          check_output("m1_tdata", m1_axis_tdata, s_dec_axis_tdata);
          check_output("m1_tuser", m1_axis_tuser, s_dec_axis_tuser);
        end
        pop = s_dec_axis_tvalid && exp_ready;
      end
      check_output("s_dec_tready", s_dec_axis_tready, exp_ready ? 1 : 0);
      if (pop) begin
        route_log.push_back(id_q[0]);
        void'(id_q.pop_front());
      end
      if (holding && m_dec_axis_tready) begin
        id_q.push_back(held_id);
        holding = 1'b0;
      end else if (do_grant) begin
        holding  = 1'b1;
        held_id  = g;
        held_str = (g == 1) ? s1_axis_tdata : s0_axis_tdata;
        last_id  = g;
        grant_log.push_back(g);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int exp_seq[4];
`ifdef AXIS_1553_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    arst              = 1'b1;
    s0_axis_tdata     = '0;
    s1_axis_tdata     = '0;
    s0_axis_tvalid    = 1'b1;
    s1_axis_tvalid    = 1'b0;
    m_dec_axis_tready = 1'b1;
    s_dec_axis_tdata  = 16'h1234;
    s_dec_axis_tuser  = 8'h01;
    s_dec_axis_tvalid = 1'b1;
    m0_axis_tready    = 1'b1;
    m1_axis_tready    = 1'b1;
    repeat (2) apply_stimulus();
    @(negedge aclk);
    check_output("lit_rst_s0_tready", s0_axis_tready, 0);
    check_output("lit_rst_orphan", orphan_err, 0);
    apply_stimulus();

    // Both requesters valid, decoder results held off: four grants fill the FIFO, fifth waits.
    arst              = 1'b0;
    s1_axis_tvalid    = 1'b1;
    s_dec_axis_tvalid = 1'b0;
    grant_log.delete();
    route_log.delete();
    repeat (10) apply_stimulus();
    check_output("lit_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_output($sformatf("lit_grant_%0d", i), grant_log[i], exp_seq[i]);
    @(negedge aclk);
    check_output("lit_full_s0_tready", s0_axis_tready, 0);
    check_output("lit_full_s1_tready", s1_axis_tready, 0);
    apply_stimulus();

    // Drain the four results; they must route in grant order.
    s0_axis_tvalid    = 1'b0;
    s1_axis_tvalid    = 1'b0;
    s_dec_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_dec_axis_tdata = 16'(16'h0100 + i);
      s_dec_axis_tuser = 8'(i);
      apply_stimulus();
    end
    s_dec_axis_tvalid = 1'b0;
    check_output("lit_route_count", route_log.size(), 4);
    for (int i = 0; i < 4 && i < route_log.size(); i++)
      check_output($sformatf("lit_route_%0d", i), route_log[i], exp_seq[i]);

    // Head ID 1 with requester 1 stalled: decoder must be back-pressured.
    s1_axis_tvalid = 1'b1;
    apply_stimulus();
    s1_axis_tvalid = 1'b0;
    apply_stimulus();
    s_dec_axis_tvalid = 1'b1;
    s_dec_axis_tdata  = 16'hA5F0;
    s_dec_axis_tuser  = 8'h0D;
    m1_axis_tready    = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      check_output("lit_stall_s_dec_tready", s_dec_axis_tready, 0);
      check_output("lit_stall_m1_tvalid", m1_axis_tvalid, 1);
      apply_stimulus();
    end
    m1_axis_tready = 1'b1;
    @(negedge aclk);
    check_output("lit_release_s_dec_tready", s_dec_axis_tready, 1);
    check_output("lit_release_m1_tdata", m1_axis_tdata, 16'hA5F0);
    check_output("lit_release_m1_tuser", m1_axis_tuser, 8'h0D);
    apply_stimulus();

    // FIFO now empty: a returning word is an orphan for exactly that cycle.
    @(negedge aclk);
    check_output("lit_orphan_pulse", orphan_err, 1);
    check_output("lit_orphan_m0_tvalid", m0_axis_tvalid, 0);
    check_output("lit_orphan_m1_tvalid", m1_axis_tvalid, 0);
    apply_stimulus();
    s_dec_axis_tvalid = 1'b0;
    @(negedge aclk);
    check_output("lit_orphan_end", orphan_err, 0);
    apply_stimulus();

    // Two IDs outstanding and a third request held, then reset.
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b1;
    repeat (5) apply_stimulus();
    m_dec_axis_tready = 1'b0;
    @(negedge aclk);
    check_output("lit_pre_rst_hold", m_dec_axis_tvalid, 1);
    apply_stimulus();
    arst = 1'b1;
    apply_stimulus();
    arst              = 1'b0;
    s_dec_axis_tvalid = 1'b1;
    @(negedge aclk);
    check_output("lit_post_rst_m_dec_tvalid", m_dec_axis_tvalid, 0);
    check_output("lit_post_rst_orphan", orphan_err, 1);
    check_output("lit_post_rst_s0_tready", s0_axis_tready, 1);
    check_output("lit_post_rst_s1_tready", s1_axis_tready, 0);
    apply_stimulus();
    s_dec_axis_tvalid = 1'b0;
    s0_axis_tvalid    = 1'b0;
    s1_axis_tvalid    = 1'b0;
    m_dec_axis_tready = 1'b1;
    repeat (4) apply_stimulus();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_1553_string_arbiter.md
AXIS_1553_STRING_ARBITER -- requirements
Module: axis_1553_string_arbiter

Interface
REQ-001 SHALL have parameter STR_WIDTH, default 176, giving the ASCII command string width.
REQ-002 SHALL have parameter ID_DEPTH, default 4, giving the in-flight ID FIFO depth (power of 2, at least 2).
REQ-003 SHALL have the port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have the port arst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have the ports s0_axis_tdata/tvalid/tready, input/input/output, STR_WIDTH/1/1: requester 0 string stream.
REQ-006 SHALL have the ports s1_axis_tdata/tvalid/tready, input/input/output, STR_WIDTH/1/1: requester 1 string stream.
REQ-007 SHALL have the ports m_dec_axis_tdata/tvalid/tready, output/output/input, STR_WIDTH/1/1: the string to the shared axis_1553_string_decoder.
REQ-008 SHALL have the ports s_dec_axis_tdata/tuser/tvalid/tready, input/input/input/output, 16/8/1/1: the decoded word returning from the decoder.
REQ-009 SHALL have the ports m0_axis_tdata/tuser/tvalid/tready, output/output/output/input, 16/8/1/1: the decoded result routed to requester 0.
REQ-010 SHALL have the ports m1_axis_tdata/tuser/tvalid/tready, output/output/output/input, 16/8/1/1: the decoded result routed to requester 1.
REQ-011 SHALL have the port orphan_err, output, 1 bit: one-cycle pulse when the decoder returns a word with no ID outstanding.

Function
REQ-012 Request FSM SHALL have two states: IDLE and HOLD.
REQ-013 In IDLE, when at least one sN_axis_tvalid is high and the ID FIFO is not full, the block SHALL assert tready to exactly one requester for one cycle, capture its tdata, and go to HOLD.
REQ-014 Requester tready SHALL be low in HOLD, and in IDLE while the FIFO is full.
REQ-015 Arbitration SHALL be round-robin: with both requesters valid, grant the port not granted last; with one valid, grant that port.
REQ-016 In HOLD, m_dec_axis_tvalid SHALL be 1 with tdata stable; the grant takes effect on cycle N and tvalid rises on N+1.
REQ-017 On the m_dec handshake, the block SHALL push the granted port ID into the FIFO and return to IDLE, giving at most one grant per two cycles.
REQ-018 FIFO occupancy SHALL count 0..ID_DEPTH; a simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo ID_DEPTH.
REQ-019 mN_axis_tvalid SHALL equal s_dec_axis_tvalid AND FIFO not empty AND head ID == N, combinationally.
REQ-020 mN_axis_tdata/tuser SHALL pass s_dec_axis_tdata/tuser through unregistered.
REQ-021 With the FIFO not empty, s_dec_axis_tready SHALL equal the tready of the head-ID output.
REQ-022 A pop SHALL occur on the s_dec handshake.
REQ-023 With the FIFO empty, s_dec_axis_tready SHALL be 1, the word SHALL be discarded, and orphan_err SHALL pulse on that cycle.
REQ-024 A held string SHALL NOT be altered or withdrawn before the m_dec handshake.

Reset
REQ-025 While arst=1 at an edge, the FSM SHALL enter IDLE, FIFO count and pointers SHALL clear, the round-robin pointer SHALL be set so port 0 wins first, and orphan_err, all tready and all tvalid outputs SHALL be 0.
REQ-026 Reset mid-operation SHALL discard the held string and all outstanding IDs; no stale word is routed after reset.

Configuration
REQ-027 Macro AXIS_1553_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with port 0 always winning and the round-robin pointer removed; when undefined, REQ-015 applies.

Structure
REQ-028 Package axis_1553_pkg SHALL hold the port-ID type (1 bit), the FSM state enum, and the decoded widths (16, 8).
REQ-029 The ID FIFO SHALL be a sub-module named axis_1553_id_fifo with push, pop, full, empty and head outputs.

Verification
REQ-030 Both requesters valid continuously, decoder always ready -> grants alternate 0,1,0,1; results return to m0, m1, m0, m1 in order.
REQ-031 Decoder returns {16'hA5F0, 8'h0D} with head ID 1 and m1 tready=0 -> s_dec_axis_tready=0 and no pop until m1 tready=1.
REQ-032 Decoder outputs held off, 5 requests -> 4 pushes, then both requester treadys stay low until one pop.
REQ-033 s_dec_axis_tvalid=1 with FIFO empty -> orphan_err pulses for exactly 1 cycle; m0/m1 tvalid stay 0.
REQ-034 arst asserted in HOLD with 2 IDs outstanding -> next cycle m_dec tvalid=0 and count=0; first post-reset grant goes to port 0.
REQ-035 With AXIS_1553_ARB_FIXED_PRIO_EN defined and both requesters valid -> port 0 is granted on every grant.
